// File: rtl/serial_subtractor_ctrl.sv
// serial_subtractor_ctrl: bit-serial subtractor computing diff = a - b - bin.
// One full_subtractor cell is reused over WIDTH cycles, LSB first, with a
// valid/ready handshake on the operand side and on the result side.
// Optional build macro SERSUB_SIGNED_OVF_EN adds a registered two's-complement
// overflow flag (ovf) next to diff; without it there is no ovf port or logic.

// Single-bit subtractor cell: d = x - y - bi, with borrow-out bo.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic d,
    output logic bo
);

    // A borrow comes out when y exceeds x, or when they are equal and a borrow came in.
    always_comb begin
        d  = x ^ y ^ bi;
        bo = (~x & y) | (~(x ^ y) & bi);
    end

endmodule

module serial_subtractor_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             busy
`ifdef SERSUB_SIGNED_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-2:0] res_sh;
    logic             brw;
    logic [CW-1:0]    cnt;

    logic             cell_d;
    logic             cell_bo;
    logic [WIDTH-1:0] res_next;

    full_subtractor u_cell (
        .x  (a_sh[0]),
        .y  (b_sh[0]),
        .bi (brw),
        .d  (cell_d),
        .bo (cell_bo)
    );

    // The result shift register only holds the first WIDTH-1 bits; the final
    // bit goes straight from the cell into diff on the last RUN edge.
    always_comb begin
        res_next = {cell_d, res_sh};
    end

    // Sequencer: accept operands, run WIDTH serial steps, hold the result until taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            diff      <= '0;
            bout      <= 1'b0;
            a_sh      <= '0;
            b_sh      <= '0;
            res_sh    <= '0;
            brw       <= 1'b0;
            cnt       <= '0;
`ifdef SERSUB_SIGNED_OVF_EN
            ovf       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_sh     <= a;
                        b_sh     <= b;
                        brw      <= bin;
                        cnt      <= '0;
                        state    <= RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    res_sh <= res_next[WIDTH-1:1];
                    brw    <= cell_bo;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        diff      <= res_next;
                        bout      <= cell_bo;
`ifdef SERSUB_SIGNED_OVF_EN
                        ovf       <= (a_sh[0] != b_sh[0]) && (cell_d != a_sh[0]);
`endif
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// tb_serial_subtractor_ctrl: directed-vector bench for serial_subtractor_ctrl
// with WIDTH=8. Define SERSUB_SIGNED_OVF_EN to also exercise the ovf output.

module tb_serial_subtractor_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         bout;
    logic         busy;
`ifdef SERSUB_SIGNED_OVF_EN
    logic         ovf;
`endif

    int vectors     = 0;
    int miscompares = 0;

    serial_subtractor_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .busy      (busy)
`ifdef SERSUB_SIGNED_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one operand set for a single edge; caller guarantees the block is idle.
    task automatic accept(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi);
        a        = av;
        b        = bv;
        bin      = bi;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Counts edges until out_valid is seen, giving up after 40.
    task automatic wait_done(output int n);
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; bin = 1'b0;
        repeat (2) tick();
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        vectors++; if (diff !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_diff: got %h expected 00", diff); end
        vectors++; if (bout !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_bout: got %b expected 0", bout); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int n;
        out_ready = 1'b1;
        accept(8'h5A, 8'h3C, 1'b0);
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL basic_busy: got %b expected 1", busy); end
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL basic_in_ready_run: got %b expected 0", in_ready); end
        wait_done(n);
        vectors++; if (n !== W) begin miscompares++; $display("[TB] FAIL basic_latency: got %0d expected %0d", n, W); end
        vectors++; if (diff !== 8'h1E) begin miscompares++; $display("[TB] FAIL basic_diff: got %h expected 1e", diff); end
        vectors++; if (bout !== 1'b0) begin miscompares++; $display("[TB] FAIL basic_bout: got %b expected 0", bout); end
        tick();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL basic_out_valid_drop: got %b expected 0", out_valid); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL basic_in_ready_back: got %b expected 1", in_ready); end
        vectors++; if (diff !== 8'h1E) begin miscompares++; $display("[TB] FAIL basic_diff_held: got %h expected 1e", diff); end
    endtask

    task automatic test_borrow();
        int n;
        out_ready = 1'b1;
        accept(8'h00, 8'h01, 1'b0);
        wait_done(n);
        vectors++; if (n !== W) begin miscompares++; $display("[TB] FAIL borrow1_latency: got %0d expected %0d", n, W); end
        vectors++; if (diff !== 8'hFF) begin miscompares++; $display("[TB] FAIL borrow1_diff: got %h expected ff", diff); end
        vectors++; if (bout !== 1'b1) begin miscompares++; $display("[TB] FAIL borrow1_bout: got %b expected 1", bout); end
        tick();
        accept(8'hFF, 8'hFF, 1'b1);
        wait_done(n);
        vectors++; if (n !== W) begin miscompares++; $display("[TB] FAIL borrow2_latency: got %0d expected %0d", n, W); end
        vectors++; if (diff !== 8'hFF) begin miscompares++; $display("[TB] FAIL borrow2_diff: got %h expected ff", diff); end
        vectors++; if (bout !== 1'b1) begin miscompares++; $display("[TB] FAIL borrow2_bout: got %b expected 1", bout); end
        tick();
    endtask

    task automatic test_backpressure();
        int n;
        out_ready = 1'b0;
        accept(8'h5A, 8'h3C, 1'b0);
        wait_done(n);
        vectors++; if (n !== W) begin miscompares++; $display("[TB] FAIL bp_latency: got %0d expected %0d", n, W); end
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0];
            a = 8'hAA; b = 8'h11; bin = 1'b1;
            tick();
            vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL bp_out_valid[%0d]: got %b expected 1", i, out_valid); end
            vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_in_ready[%0d]: got %b expected 0", i, in_ready); end
            vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_busy[%0d]: got %b expected 0", i, busy); end
            vectors++; if (diff !== 8'h1E) begin miscompares++; $display("[TB] FAIL bp_diff[%0d]: got %h expected 1e", i, diff); end
            vectors++; if (bout !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_bout[%0d]: got %b expected 0", i, bout); end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_release_out_valid: got %b expected 0", out_valid); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL bp_release_in_ready: got %b expected 1", in_ready); end
        tick();
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_not_queued: got busy %b expected 0", busy); end
        vectors++; if (diff !== 8'h1E) begin miscompares++; $display("[TB] FAIL bp_diff_after: got %h expected 1e", diff); end
    endtask

    task automatic test_reset_mid();
        int n;
        logic seen;
        out_ready = 1'b1;
        accept(8'hF0, 8'h0F, 1'b0);
        repeat (2) tick();
        #2 rst = 1'b1;
        #1;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL rstmid_busy: got %b expected 0", busy); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL rstmid_in_ready: got %b expected 1", in_ready); end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rstmid_out_valid: got %b expected 0", out_valid); end
        vectors++; if (diff !== 8'h00) begin miscompares++; $display("[TB] FAIL rstmid_diff: got %h expected 00", diff); end
        vectors++; if (bout !== 1'b0) begin miscompares++; $display("[TB] FAIL rstmid_bout: got %b expected 0", bout); end
        tick();
        rst  = 1'b0;
        seen = 1'b0;
        repeat (12) begin
            tick();
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        vectors++; if (seen !== 1'b0) begin miscompares++; $display("[TB] FAIL rstmid_no_out_valid: got %b expected 0", seen); end
        accept(8'hF0, 8'h0F, 1'b0);
        wait_done(n);
        vectors++; if (n !== W) begin miscompares++; $display("[TB] FAIL rstmid_fresh_latency: got %0d expected %0d", n, W); end
        vectors++; if (diff !== 8'hE1) begin miscompares++; $display("[TB] FAIL rstmid_fresh_diff: got %h expected e1", diff); end
        vectors++; if (bout !== 1'b0) begin miscompares++; $display("[TB] FAIL rstmid_fresh_bout: got %b expected 0", bout); end
        tick();
    endtask

    task automatic test_back_to_back();
        int n;
        out_ready = 1'b1;
        a = 8'h5A; b = 8'h3C; bin = 1'b0;
        in_valid = 1'b1;
        tick();
        a = 8'h00; b = 8'h01; bin = 1'b0;
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_first_busy: got %b expected 1", busy); end
        wait_done(n);
        vectors++; if (n !== W) begin miscompares++; $display("[TB] FAIL b2b_first_latency: got %0d expected %0d", n, W); end
        vectors++; if (diff !== 8'h1E) begin miscompares++; $display("[TB] FAIL b2b_first_diff: got %h expected 1e", diff); end
        tick();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_handshake_out_valid: got %b expected 0", out_valid); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_no_same_cycle_accept: got busy %b expected 0", busy); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_idle_in_ready: got %b expected 1", in_ready); end
        tick();
        in_valid = 1'b0;
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_second_busy: got %b expected 1", busy); end
        wait_done(n);
        vectors++; if (n !== W) begin miscompares++; $display("[TB] FAIL b2b_second_latency: got %0d expected %0d", n, W); end
        vectors++; if (diff !== 8'hFF) begin miscompares++; $display("[TB] FAIL b2b_second_diff: got %h expected ff", diff); end
        vectors++; if (bout !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_second_bout: got %b expected 1", bout); end
        tick();
    endtask

`ifdef SERSUB_SIGNED_OVF_EN
    task automatic test_ovf();
        int n;
        out_ready = 1'b1;
        accept(8'h80, 8'h01, 1'b0);
        wait_done(n);
        vectors++; if (diff !== 8'h7F) begin miscompares++; $display("[TB] FAIL ovf1_diff: got %h expected 7f", diff); end
        vectors++; if (ovf !== 1'b1) begin miscompares++; $display("[TB] FAIL ovf1_ovf: got %b expected 1", ovf); end
        tick();
        accept(8'h10, 8'h01, 1'b0);
        wait_done(n);
        vectors++; if (diff !== 8'h0F) begin miscompares++; $display("[TB] FAIL ovf2_diff: got %h expected 0f", diff); end
        vectors++; if (ovf !== 1'b0) begin miscompares++; $display("[TB] FAIL ovf2_ovf: got %b expected 0", ovf); end
        tick();
    endtask
`endif

    // Runs every scenario in order, then reports the totals.
    initial begin
        test_reset();
        test_basic();
        test_borrow();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
`ifdef SERSUB_SIGNED_OVF_EN
        test_ovf();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
